// File: rtl/com_tracker.sv
// Centroid tracker: EMA-smoothed position, per-update delta, outlier gate and
// lock/loss supervision fed by one centroid pulse per frame.
module com_tracker #(
   parameter int ALPHA_SHIFT = 2,
   parameter int JUMP_THRESH = 200,
   parameter int LOST_FRAMES = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] x_in,
   input  logic [9:0]  y_in,
   input  logic        valid_in,
   input  logic        frame_done_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic [11:0] dx_out,
   output logic [10:0] dy_out,
   output logic        valid_out,
   output logic        locked_out,
   output logic        lost_out
);
   localparam int AXW = 11 + ALPHA_SHIFT;
   localparam int AYW = 10 + ALPHA_SHIFT;
   localparam logic [11:0] THRESH = 12'(JUMP_THRESH);
   localparam logic [7:0]  LOST_N = 8'(LOST_FRAMES);

   typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_TRACK = 1'b1} state_t;

   function automatic logic [11:0] abs12(input logic [11:0] v);
      abs12 = v[11] ? (12'd0 - v) : v;
   endfunction

   logic [1:0]     rst_sync_r;
   logic           rst_n_s;
   state_t         state_r, state_nx_s;
   logic           s1_valid_r, s1_seed_r, s1_accept_r;
   logic [10:0]    s1_x_r;
   logic [9:0]     s1_y_r;
   logic [AXW-1:0] acc_x_r, acc_x_nx_s;
   logic [AYW-1:0] acc_y_r, acc_y_nx_s;
   logic [10:0]    x_r, x_new_s;
   logic [9:0]     y_r, y_new_s;
   logic [11:0]    dx_r, dx_in_s;
   logic [10:0]    dy_r, dy_in_s;
   logic           valid_r, locked_r, lost_r;
   logic [7:0]     miss_r, miss_inc_s;
   logic           got_r;
   logic           gate_ok_s, take_s, seed_now_s, accept_now_s;
   logic           frame_end_s, credited_s, lose_s;
   logic           seed_s, update_s, valid_nx_s, locked_nx_s;

   assign x_out      = x_r;
   assign y_out      = y_r;
   assign dx_out     = dx_r;
   assign dy_out     = dy_r;
   assign valid_out  = valid_r;
   assign locked_out = locked_r;
   assign lost_out   = lost_r;

   // Reset synchronizer: asserts immediately, releases on the second clock edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) rst_sync_r <= 2'b00;
      else         rst_sync_r <= {rst_sync_r[0], 1'b1};
   end
   assign rst_n_s = rst_sync_r[1];

   // Stage-1 admission, outlier gate and frame-credit decisions.
   always_comb begin
      dx_in_s      = {1'b0, x_in} - {1'b0, x_r};
      dy_in_s      = {1'b0, y_in} - {1'b0, y_r};
      gate_ok_s    = (abs12(dx_in_s) <= THRESH) && (abs12({dy_in_s[10], dy_in_s}) <= THRESH);
      take_s       = valid_in && !s1_valid_r;
      seed_now_s   = take_s && (state_r == ST_SEARCH);
      accept_now_s = take_s && (state_r == ST_TRACK) && gate_ok_s;
      frame_end_s  = frame_done_in && (state_r == ST_TRACK);
      credited_s   = got_r || accept_now_s;
      miss_inc_s   = miss_r + 8'd1;
      lose_s       = frame_end_s && !credited_s && (miss_inc_s == LOST_N);
   end

   // Stage-2 EMA arithmetic; the accumulator cannot exceed the max input << ALPHA_SHIFT.
   always_comb begin
      acc_x_nx_s = acc_x_r - (acc_x_r >> ALPHA_SHIFT) + AXW'(s1_x_r);
      acc_y_nx_s = acc_y_r - (acc_y_r >> ALPHA_SHIFT) + AYW'(s1_y_r);
      x_new_s    = acc_x_nx_s[ALPHA_SHIFT +: 11];
      y_new_s    = acc_y_nx_s[ALPHA_SHIFT +: 10];
   end

   // Tracker state register.
   always_ff @(posedge clk_in or negedge rst_n_s) begin
      if (!rst_n_s) state_r <= ST_SEARCH;
      else          state_r <= state_nx_s;
   end

   // Next-state: a seed locks, a lost-frame limit drops back to search.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_SEARCH: begin
            if (seed_s) state_nx_s = ST_TRACK;
            else        state_nx_s = ST_SEARCH;
         end
         ST_TRACK: begin
            if (lose_s) state_nx_s = ST_SEARCH;
            else        state_nx_s = ST_TRACK;
         end
         default: state_nx_s = ST_SEARCH;
      endcase
   end

   // Output decode for the stage-2 update.
   always_comb begin
      seed_s      = s1_valid_r && s1_seed_r;
      update_s    = s1_valid_r && s1_accept_r;
      valid_nx_s  = seed_s || update_s;
      locked_nx_s = (state_nx_s == ST_TRACK);
   end

   // Stage-1 sample register.
   always_ff @(posedge clk_in or negedge rst_n_s) begin
      if (!rst_n_s) begin
         s1_valid_r  <= 1'b0;
         s1_seed_r   <= 1'b0;
         s1_accept_r <= 1'b0;
         s1_x_r      <= 11'd0;
         s1_y_r      <= 10'd0;
      end else begin
         s1_valid_r <= take_s;
         if (take_s) begin
            s1_seed_r   <= seed_now_s;
            s1_accept_r <= accept_now_s;
            s1_x_r      <= x_in;
            s1_y_r      <= y_in;
         end
      end
   end

   // Miss counter: a sample taken in the frame-done cycle credits the ending frame.
   always_ff @(posedge clk_in or negedge rst_n_s) begin
      if (!rst_n_s) begin
         miss_r <= 8'd0;
         got_r  <= 1'b0;
      end else if (state_r != ST_TRACK) begin
         miss_r <= 8'd0;
         got_r  <= 1'b0;
      end else if (frame_end_s) begin
         got_r  <= 1'b0;
         miss_r <= (credited_s || lose_s) ? 8'd0 : miss_inc_s;
      end else if (accept_now_s) begin
         got_r <= 1'b1;
      end
   end

   // Accumulators and registered outputs.
   always_ff @(posedge clk_in or negedge rst_n_s) begin
      if (!rst_n_s) begin
         acc_x_r  <= '0;
         acc_y_r  <= '0;
         x_r      <= 11'd0;
         y_r      <= 10'd0;
         dx_r     <= 12'd0;
         dy_r     <= 11'd0;
         valid_r  <= 1'b0;
         locked_r <= 1'b0;
         lost_r   <= 1'b0;
      end else begin
         if (seed_s) begin
            acc_x_r <= AXW'(s1_x_r) << ALPHA_SHIFT;
            acc_y_r <= AYW'(s1_y_r) << ALPHA_SHIFT;
            x_r     <= s1_x_r;
            y_r     <= s1_y_r;
            dx_r    <= 12'd0;
            dy_r    <= 11'd0;
         end else if (update_s) begin
            acc_x_r <= acc_x_nx_s;
            acc_y_r <= acc_y_nx_s;
            x_r     <= x_new_s;
            y_r     <= y_new_s;
            dx_r    <= {1'b0, x_new_s} - {1'b0, x_r};
            dy_r    <= {1'b0, y_new_s} - {1'b0, y_r};
         end
         valid_r  <= valid_nx_s;
         locked_r <= locked_nx_s;
         lost_r   <= lose_s;
      end
   end
endmodule

// File: doc/com_tracker.md
Name: com_tracker

Overview:
Downstream consumer of the per-frame centroid stage. Takes one (x,y) centroid pulse per frame and produces an exponentially smoothed position and a per-update velocity (delta). Rejects outlier jumps and tracks lock/loss state across frames. Feeds overlay/game logic with a stable target position.

Parameters:
ALPHA_SHIFT, 2, EMA weight = 1/2^ALPHA_SHIFT; legal range 0..4 (0 = no smoothing).
JUMP_THRESH, 200, max |input − smoothed| per axis (pixels) accepted while tracking.
LOST_FRAMES, 8, consecutive frames without an accepted sample before lock is dropped; legal range 1..255.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset (0 = reset)
x_in  input  11  centroid x, unsigned pixels
y_in  input  10  centroid y, unsigned pixels
valid_in  input  1  single-cycle pulse, x_in/y_in valid
frame_done_in  input  1  single-cycle pulse at end of each frame
x_out  output  11  smoothed x
y_out  output  10  smoothed y
dx_out  output  12  signed x change vs previous x_out
dy_out  output  11  signed y change vs previous y_out
valid_out  output  1  single-cycle pulse, outputs updated
locked_out  output  1  level, tracker holds a valid lock
lost_out  output  1  single-cycle pulse on lock loss

Behaviour:
- Reset (rst_in=0, async assert, sync-released internally by clk edge): all outputs 0, accumulators 0, miss counter 0, state SEARCH.
- Internal accumulators acc_x (11+ALPHA_SHIFT bits) and acc_y (10+ALPHA_SHIFT bits) hold smoothed position << ALPHA_SHIFT. x_out = acc_x >> ALPHA_SHIFT (truncate); same for y.
- Two-stage pipeline: stage 1 registers inputs and computes signed diffs vs current smoothed value plus gate decision; stage 2 updates accumulators/outputs. valid_in at cycle N -> valid_out high at cycle N+2 (accepted samples only).
- valid_in arriving while a sample occupies stage 1 is dropped (no effect, not counted as accepted).
- States:
  - SEARCH: any valid_in is accepted as seed: acc = in << ALPHA_SHIFT, dx_out=dy_out=0, valid_out pulse, locked_out<=1, -> TRACK, miss counter cleared.
  - TRACK: if |x_in−x_out| > JUMP_THRESH or |y_in−y_out| > JUMP_THRESH: rejected, no valid_out, outputs hold. Otherwise acc_new = acc − (acc >> ALPHA_SHIFT) + in; dx_out = new x_out − old x_out (signed, full precision, no overflow possible); valid_out pulse.
- Miss counting (TRACK only): frame_done_in with no accepted sample since previous frame_done_in increments miss counter; a frame with an accepted sample clears it. valid_in and frame_done_in in the same cycle: sample is credited to the ending frame (gate result applies one cycle later; credit computed from stage-1 decision).
- When miss counter reaches LOST_FRAMES: -> SEARCH, locked_out<=0, lost_out pulse one cycle, miss counter cleared; x_out/y_out hold last values, dx/dy unchanged.
- frame_done_in in SEARCH: no effect.
- Reset mid-pipeline: in-flight sample discarded, no valid_out after release.

Test Plan:
- Reset, then valid_in (100,50) -> 2 cycles later valid_out, x_out=100, y_out=50, dx=dy=0, locked_out=1.
- ALPHA_SHIFT=2, after seed (100,50) send (108,50) -> x_out=102, y_out=50, dx_out=+2, dy_out=0; then (90,50) -> x_out=99, dx_out=−3.
- Tracking at x=102, send (400,50) -> no valid_out, x_out stays 102; with frame_done_in same frame counts as miss.
- Tracking, 8 frame_done_in pulses with no valid_in -> on 8th, lost_out 1-cycle pulse, locked_out=0; then valid_in (500,300) -> seed, x_out=500, y_out=300, dx=0, locked_out=1.
- valid_in and frame_done_in same cycle for 10 frames -> miss counter never increments, locked_out stays 1; back-to-back valid_in cycles -> only first accepted, single valid_out.
- Drive rst_in low 1 cycle after valid_in while tracking -> all outputs 0 immediately, no valid_out after release, state SEARCH.
